// File: rtl/rf_pkg.sv
// Shared widths, request type and arbiter state encoding for the register-file write path.
// Latency: none (declarations only). Backpressure: n/a.
// Imported by rf_write_arbiter, rf_wr_prio_fsm and their bench.
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = '0;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_req_t;

  typedef enum logic {
    PRI_WB  = 1'b0,
    PRI_MDU = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rf_wr_prio_fsm.sv
// Fixed WB-over-MDU priority with a starvation guard that hands MDU one forced win.
// Latency: grants are combinational from valids and state. Backpressure: loser simply sees no grant.
// State advances only on cycles where requests are presented.
module rf_wr_prio_fsm
  import rf_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wb_valid,
  input  logic mdu_valid,
  output logic grant_wb,
  output logic grant_mdu,
  output logic starved
);

  localparam int CNT_W = (STARVE_LIMIT > 8) ? $clog2(STARVE_LIMIT) : 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] lose_cnt_q, lose_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PRI_WB;
      lose_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lose_cnt_q <= lose_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lose_cnt_d = lose_cnt_q;
    grant_wb   = 1'b0;
    grant_mdu  = 1'b0;
    unique case (state_q)
      PRI_WB: begin
        if (wb_valid) begin
          grant_wb = 1'b1;
          // Only a contested WB win counts as an MDU loss.
          if (mdu_valid) begin
            if (lose_cnt_q == CNT_LAST) begin
              state_d    = PRI_MDU;
              lose_cnt_d = '0;
            end else begin
              lose_cnt_d = lose_cnt_q + 1'b1;
            end
          end
        end else if (mdu_valid) begin
          grant_mdu  = 1'b1;
          lose_cnt_d = '0;
        end
      end
      PRI_MDU: begin
        if (mdu_valid) begin
          grant_mdu = 1'b1;
          state_d   = PRI_WB;
        end else if (wb_valid) begin
          grant_wb = 1'b1;
        end
      end
      default: state_d = PRI_WB;
    endcase
  end

  assign starved = (state_q == PRI_MDU);

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates WB and MDU onto the register file write port; RF_WRITE_FWD_EN adds ID-stage forwarding.
// Latency: accept in cycle N -> rf_we/rf_waddr/rf_wdata in cycle N+1. Backpressure: combinational ready, one per cycle.
// Writes to register 0 are accepted but never raise rf_we.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W       = RF_DATA_W,
  parameter int ADDR_W       = RF_ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_addr,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
`ifdef RF_WRITE_FWD_EN
  input  logic [ADDR_W-1:0] fwd_raddr1,
  input  logic [ADDR_W-1:0] fwd_raddr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              starved
);

  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(RF_ZERO_REG);

  logic              grant_wb, grant_mdu;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  rf_wr_prio_fsm #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio_fsm (
    .clk       (clk),
    .rst_n     (rst),
    .wb_valid  (wb_valid),
    .mdu_valid (mdu_valid),
    .grant_wb  (grant_wb),
    .grant_mdu (grant_mdu),
    .starved   (starved)
  );

  // No handshake may complete while reset is held.
  assign wb_ready  = rst & grant_wb;
  assign mdu_ready = rst & grant_mdu;

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (wb_ready) begin
      rf_we_d    = (wb_addr != ZERO_REG);
      rf_waddr_d = wb_addr;
      rf_wdata_d = wb_data;
    end else if (mdu_ready) begin
      rf_we_d    = (mdu_addr != ZERO_REG);
      rf_waddr_d = mdu_addr;
      rf_wdata_d = mdu_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef RF_WRITE_FWD_EN
  // Lets ID consume the in-flight write before the register file commits it.
  assign fwd_hit1 = rf_we_q & (rf_waddr_q == fwd_raddr1) & (fwd_raddr1 != ZERO_REG);
  assign fwd_hit2 = rf_we_q & (rf_waddr_q == fwd_raddr2) & (fwd_raddr2 != ZERO_REG);
  assign fwd_data = rf_wdata_q;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed and random bench for rf_write_arbiter against a counting reference model.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, mdu_valid;
  logic [4:0]  wb_addr, mdu_addr;
  logic [31:0] wb_data, mdu_data;
  logic        wb_ready, mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        starved;
`ifdef RF_WRITE_FWD_EN
  logic [4:0]  fwd_raddr1, fwd_raddr2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data;
`endif

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .wb_ready  (wb_ready),
    .mdu_valid (mdu_valid),
    .mdu_addr  (mdu_addr),
    .mdu_data  (mdu_data),
    .mdu_ready (mdu_ready),
`ifdef RF_WRITE_FWD_EN
    .fwd_raddr1(fwd_raddr1),
    .fwd_raddr2(fwd_raddr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data  (fwd_data),
`endif
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .starved   (starved)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: count of contested WB wins and a pending forced MDU win.
  int         losses    = 0;
  bit         force_mdu = 1'b0;
  rf_wr_req_t exp_rf    = '0;
  bit         ad_known  = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_rf    = '0;
    ad_known  = 1'b1;
    losses    = 0;
    force_mdu = 1'b0;
  endtask

  task automatic step(input bit r,
                      input bit wv, input logic [4:0] wa, input logic [31:0] wd,
                      input bit mv, input logic [4:0] ma, input logic [31:0] md,
                      output bit gw, output bit gm);
    @(negedge clk);
    chk("rf_we", 64'(rf_we), 64'(exp_rf.valid));
    if (ad_known) begin
      chk("rf_waddr", 64'(rf_waddr), 64'(exp_rf.addr));
      chk("rf_wdata", 64'(rf_wdata), 64'(exp_rf.data));
    end
    chk("starved", 64'(starved), 64'(force_mdu));
    rst = r;
    wb_valid = wv;  wb_addr = wa;  wb_data = wd;
    mdu_valid = mv; mdu_addr = ma; mdu_data = md;
    #1;
    gw = 1'b0;
    gm = 1'b0;
    if (r) begin
      if (force_mdu) begin
        if (mv) gm = 1'b1; else if (wv) gw = 1'b1;
      end else begin
        if (wv) gw = 1'b1; else if (mv) gm = 1'b1;
      end
    end
    chk("wb_ready", 64'(wb_ready), 64'(gw));
    chk("mdu_ready", 64'(mdu_ready), 64'(gm));
    if (!r) begin
      model_reset();
    end else begin
      if (gw || gm) begin
        exp_rf.addr  = gw ? wa : ma;
        exp_rf.data  = gw ? wd : md;
        exp_rf.valid = (exp_rf.addr != 5'd0);
        ad_known     = exp_rf.valid;
      end else begin
        exp_rf.valid = 1'b0;
      end
      if (force_mdu) begin
        if (gm) force_mdu = 1'b0;
      end else if (gw && mv) begin
        losses++;
        if (losses == LIMIT) begin
          force_mdu = 1'b1;
          losses    = 0;
        end
      end else if (gm) begin
        losses = 0;
      end
    end
  endtask

  initial begin
    bit gw, gm;
    bit wp, mp, r;
    logic [4:0]  wa, ma;
    logic [31:0] wd, md;

    rst = 1'b0;
    wb_valid = 1'b0;  wb_addr = '0;  wb_data = '0;
    mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0;
`ifdef RF_WRITE_FWD_EN
    fwd_raddr1 = 5'd9;
    fwd_raddr2 = 5'd0;
`endif

    // Reset held with both requesting: nothing accepted.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 5'd3, 32'h1111, 1'b1, 5'd4, 32'h2222, gw, gm);

    // Both valid continuously from release: WB x4, forced MDU, then WB.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 5'(5 + i), 32'h100 + i, 1'b1, 5'(12 + i), 32'h200 + i, gw, gm);
      chk("starve_seq_wb", 64'(wb_ready), 64'(i != 4));
      chk("starve_seq_mdu", 64'(mdu_ready), 64'(i == 4));
      chk("starve_seq_flag", 64'(starved), 64'(i == 4));
    end

    // WB only, single write, one-cycle latency.
    step(1'b1, 1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, gw, gm);
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, gw, gm);
    chk("wb_write_we", 64'(rf_we), 64'd1);
    chk("wb_write_addr", 64'(rf_waddr), 64'd8);
    chk("wb_write_data", 64'(rf_wdata), 64'hDEADBEEF);

    // Register 0 write is accepted but suppressed.
    step(1'b1, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0, gw, gm);
    chk("r0_ready", 64'(wb_ready), 64'd1);
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, gw, gm);
    chk("r0_no_we", 64'(rf_we), 64'd0);

    // Build up two losses, accept MDU, then reset lands before the commit edge.
    step(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, gw, gm);
    step(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, gw, gm);
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd17, 32'hCAFE, gw, gm);
    chk("pre_rst_mdu_ready", 64'(mdu_ready), 64'd1);
    #2;
    rst = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, gw, gm);
    chk("rst_discard_we", 64'(rf_we), 64'd0);
    chk("rst_discard_addr", 64'(rf_waddr), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 5'(20 + i), 32'h300 + i, 1'b1, 5'(25 + i), 32'h400 + i, gw, gm);
      chk("post_rst_mdu", 64'(mdu_ready), 64'(i == 4));
    end

`ifdef RF_WRITE_FWD_EN
    step(1'b1, 1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'h0, gw, gm);
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, gw, gm);
    chk("fwd_hit1", 64'(fwd_hit1), 64'd1);
    chk("fwd_data", 64'(fwd_data), 64'h55);
    chk("fwd_hit2", 64'(fwd_hit2), 64'd0);
`endif

    // Random traffic: requesters hold until accepted, occasional reset pulses.
    wp = 1'b0; mp = 1'b0;
    wa = '0; ma = '0; wd = '0; md = '0;
    for (int i = 0; i < 400; i++) begin
      if (!wp && $urandom_range(9) < 6) begin
        wp = 1'b1; wa = 5'($urandom); wd = $urandom;
      end
      if (!mp && $urandom_range(9) < 6) begin
        mp = 1'b1; ma = 5'($urandom); md = $urandom;
      end
      r = ($urandom_range(63) != 0);
      step(r, wp, wa, wd, mp, ma, md, gw, gm);
      if (gw) wp = 1'b0;
      if (gm) mp = 1'b0;
    end
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, gw, gm);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
